// File: rtl/char_scroller.sv
// Message-window scroller: shows NUM_DISP chars of a writable 2-bit-code buffer on 7-seg displays.
// Latency: Offset moves on the advance edge; HEX is registered, 1 cycle behind Offset/buffer. Step adds 3 cycles.
// Backpressure: none; Load writes are accepted every cycle, out-of-range LoadIdx is dropped.
module char_scroller #(
    parameter int NUM_DISP  = 6,
    parameter int NUM_CHARS = 8,
    parameter int TICK_DIV  = 50000000
) (
    input  logic                         CLOCK_50,
    input  logic                         Resetn,
    input  logic                         Enable,
    input  logic                         Mode,
    input  logic                         Dir,
    input  logic                         Step,
    input  logic                         Load,
    input  logic [$clog2(NUM_CHARS)-1:0] LoadIdx,
    input  logic [1:0]                   LoadChar,
    output logic [7*NUM_DISP-1:0]        HEX,
    output logic [$clog2(NUM_CHARS)-1:0] Offset
);

    localparam int IDX_W = $clog2(NUM_CHARS);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHARS - 1);
    localparam logic [IDX_W:0]   DEPTH     = (IDX_W + 1)'(NUM_CHARS);

    // Character codes: 00 'd', 01 'E', 10 '1', 11 blank.
    function automatic logic [6:0] seg7(input logic [1:0] c);
        logic [6:0] s;
        case (c)
            2'b00:   s = 7'b1000010;
            2'b01:   s = 7'b0110000;
            2'b10:   s = 7'b1001111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Power-up message "dE1" followed by blanks.
    function automatic logic [1:0] reset_char(input int i);
        logic [1:0] c;
        case (i)
            0:       c = 2'b00;
            1:       c = 2'b01;
            2:       c = 2'b10;
            default: c = 2'b11;
        endcase
        return c;
    endfunction

    // Buffer index shown on display k; leftmost display (k = NUM_DISP-1) shows buf[off].
    function automatic logic [IDX_W-1:0] win_idx(input logic [IDX_W-1:0] off, input int k);
        int s;
        s = int'(off) + NUM_DISP - 1 - k;
        return IDX_W'(s % NUM_CHARS);
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]      offset_q, offset_d;
    logic [1:0]            msg_q [NUM_CHARS];
    logic [1:0]            msg_d [NUM_CHARS];
    logic [7*NUM_DISP-1:0] hex_q, hex_d;
    logic                  sync1_q, sync2_q, edge_q;
    logic                  tick_adv, step_adv, adv;

    // Prescaler: free-runs in auto mode while enabled, cleared in manual mode.
    always_comb begin
        presc_d  = presc_q;
        tick_adv = 1'b0;
        if (Mode) begin
            presc_d = '0;
        end else if (Enable) begin
            if (presc_q == TICK_LAST) begin
                presc_d  = '0;
                tick_adv = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // One advance per rising edge of the synchronised Step, only in manual mode.
    always_comb begin
        step_adv = Mode & sync2_q & ~edge_q;
        adv      = tick_adv | step_adv;
    end

    // Rotation offset, wrapping modulo NUM_CHARS in either direction.
    always_comb begin
        offset_d = offset_q;
        if (adv) begin
            if (!Dir) begin
                offset_d = (offset_q == LAST_IDX) ? '0 : offset_q + 1'b1;
            end else begin
                offset_d = (offset_q == '0) ? LAST_IDX : offset_q - 1'b1;
            end
        end
    end

    // Buffer write; indices beyond the buffer depth are dropped rather than wrapped.
    always_comb begin
        msg_d = msg_q;
        if (Load && ({1'b0, LoadIdx} < DEPTH)) begin
            msg_d[LoadIdx] = LoadChar;
        end
    end

    // Segment image of the current window, registered into HEX next edge.
    always_comb begin
        hex_d = '1;
        for (int k = 0; k < NUM_DISP; k++) begin
            hex_d[7*k +: 7] = seg7(msg_q[win_idx(offset_q, k)]);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            presc_q  <= '0;
            offset_q <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            hex_q    <= '1;
            for (int i = 0; i < NUM_CHARS; i++) begin
                msg_q[i] <= reset_char(i);
            end
        end else begin
            presc_q  <= presc_d;
            offset_q <= offset_d;
            sync1_q  <= Step;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            hex_q    <= hex_d;
            msg_q    <= msg_d;
        end
    end

    assign HEX    = hex_q;
    assign Offset = offset_q;

endmodule

// File: tb/tb_char_scroller.sv
module tb_char_scroller;

    localparam int ND = 3;
    localparam int NC = 4;
    localparam int TD = 4;

    localparam logic [6:0] S_D = 7'b1000010;
    localparam logic [6:0] S_E = 7'b0110000;
    localparam logic [6:0] S_1 = 7'b1001111;
    localparam logic [6:0] S_B = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode, dir, step, load;
    logic [1:0]  load_idx, load_char;
    logic [20:0] hex;
    logic [1:0]  offset;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int          m_off, m_cnt;
    int          m_msg [NC];
    bit          h1, h2, h3;
    logic [20:0] m_hex;
    logic [6:0]  seg_tab [4];

    char_scroller #(.NUM_DISP(ND), .NUM_CHARS(NC), .TICK_DIV(TD)) dut (
        .CLOCK_50(clk), .Resetn(rst_n), .Enable(en), .Mode(mode), .Dir(dir),
        .Step(step), .Load(load), .LoadIdx(load_idx), .LoadChar(load_char),
        .HEX(hex), .Offset(offset)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] render();
        logic [20:0] r;
        for (int k = 0; k < ND; k++) begin
            r[7*k +: 7] = seg_tab[m_msg[(m_off + ND - 1 - k) % NC]];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_off = 0;
        m_cnt = 0;
        m_msg[0] = 0; m_msg[1] = 1; m_msg[2] = 2; m_msg[3] = 3;
        h1 = 0; h2 = 0; h3 = 0;
        m_hex = '1;
    endtask

    // Advance model by one clock using the inputs presented now, then clock the DUT.
    task automatic tick();
        logic [20:0] nh;
        bit adv;
        nh  = render();
        adv = 0;
        if (mode) begin
            m_cnt = 0;
        end else if (en) begin
            m_cnt++;
            if (m_cnt == TD) begin
                m_cnt = 0;
                adv = 1;
            end
        end
        if (mode && h2 && !h3) adv = 1;
        h3 = h2; h2 = h1; h1 = step;
        if (adv) m_off = (m_off + (dir ? NC - 1 : 1)) % NC;
        if (load && int'(load_idx) < NC) m_msg[load_idx] = int'(load_char);
        m_hex = nh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; mode = 0; dir = 0; step = 0; load = 0; load_idx = 0; load_char = 0;
        model_reset();
        #12;
        tests_run++;
        if (hex !== 21'h1FFFFF) begin
            tests_failed++;
            $display("FAIL reset_hex got %b want all ones", hex);
        end
        tests_run++;
        if (offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_offset got %0d want 0", offset);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        tests_run++;
        if (hex !== {S_D, S_E, S_1}) begin
            tests_failed++;
            $display("FAIL reset_release_hex got %b want %b", hex, {S_D, S_E, S_1});
        end
        tests_run++;
        if (offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release_offset got %0d want 0", offset);
        end
    endtask

    task automatic test_auto();
        mode = 0; dir = 0; en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tests_run++;
            if (offset !== 2'(m_off) || hex !== m_hex) begin
                tests_failed++;
                $display("FAIL auto_step%0d got off=%0d hex=%b want off=%0d hex=%b", i, offset, hex, m_off, m_hex);
            end
            if (i == 4) begin
                tests_run++;
                if (offset !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL auto_first_tick got %0d want 1", offset);
                end
            end
            if (i == 5) begin
                tests_run++;
                if (hex !== {S_E, S_1, S_B}) begin
                    tests_failed++;
                    $display("FAIL auto_window1 got %b want %b", hex, {S_E, S_1, S_B});
                end
            end
        end
        // Prescaler now at 0, offset back at 0; run it to count 2, then freeze.
        tick(); tick();
        en = 0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL enable_hold got %0d want 0", offset);
        end
        en = 1;
        tick();
        tests_run++;
        if (offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL enable_resume_early got %0d want 0", offset);
        end
        tick();
        tests_run++;
        if (offset !== 2'd1) begin
            tests_failed++;
            $display("FAIL enable_resume_tick got %0d want 1", offset);
        end
    endtask

    task automatic test_dir_right();
        dir = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (offset !== 2'(m_off)) begin
                tests_failed++;
                $display("FAIL right_step%0d got %0d want %0d", i, offset, m_off);
            end
        end
        tests_run++;
        if (offset !== 2'd3) begin
            tests_failed++;
            $display("FAIL right_wrap got %0d want 3", offset);
        end
        tick();
        tests_run++;
        if (hex !== {S_B, S_D, S_E}) begin
            tests_failed++;
            $display("FAIL right_window got %b want %b", hex, {S_B, S_D, S_E});
        end
    endtask

    task automatic test_manual();
        int start;
        mode = 1; dir = 0; en = 1; step = 0;
        for (int i = 0; i < 4; i++) tick();
        start = m_off;
        for (int press = 0; press < 2; press++) begin
            step = 1;
            tick(); tick();
            tests_run++;
            if (offset !== 2'(start)) begin
                tests_failed++;
                $display("FAIL manual_early%0d got %0d want %0d", press, offset, start);
            end
            tick();
            tests_run++;
            if (offset !== 2'((start + 1) % NC)) begin
                tests_failed++;
                $display("FAIL manual_latency%0d got %0d want %0d", press, offset, (start + 1) % NC);
            end
            tick();
            tests_run++;
            if (hex !== m_hex) begin
                tests_failed++;
                $display("FAIL manual_hex%0d got %b want %b", press, hex, m_hex);
            end
            for (int i = 0; i < 6; i++) tick();
            tests_run++;
            if (offset !== 2'((start + 1) % NC)) begin
                tests_failed++;
                $display("FAIL manual_held%0d got %0d want %0d", press, offset, (start + 1) % NC);
            end
            step = 0;
            for (int i = 0; i < 4; i++) tick();
            start = (start + 1) % NC;
        end
    endtask

    task automatic test_load();
        tests_run++;
        if (offset !== 2'd1) begin
            tests_failed++;
            $display("FAIL load_precond got %0d want 1", offset);
        end
        load = 1; load_idx = 2'd3; load_char = 2'b01;
        tick();
        load = 0;
        tick();
        tests_run++;
        if (hex[6:0] !== S_E) begin
            tests_failed++;
            $display("FAIL load_rightmost got %b want %b", hex[6:0], S_E);
        end
        tests_run++;
        if (hex !== m_hex) begin
            tests_failed++;
            $display("FAIL load_hex got %b want %b", hex, m_hex);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            en        = ($urandom_range(0, 3) != 0);
            dir       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) step = ~step;
            load      = ($urandom_range(0, 3) == 0);
            load_idx  = 2'($urandom_range(0, 3));
            load_char = 2'($urandom_range(0, 3));
            tick();
            tests_run++;
            if (offset !== 2'(m_off)) begin
                tests_failed++;
                $display("FAIL rnd_offset cyc %0d got %0d want %0d", c, offset, m_off);
            end
            tests_run++;
            if (hex !== m_hex) begin
                tests_failed++;
                $display("FAIL rnd_hex cyc %0d got %b want %b", c, hex, m_hex);
            end
        end
        load = 0; step = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 1; en = 1; dir = 0; load = 0; step = 0;
        tick();
        mode = 0;
        load = 1; load_idx = 2'd1; load_char = 2'b11;
        tick();
        load = 0;
        n = 0;
        while (!(m_off == 2 && m_cnt == 2) && n < 64) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 64) begin
            tests_failed++;
            $display("FAIL reset_mid_setup got timeout want off=2 cnt=2");
        end
        tests_run++;
        if (offset !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_mid_pre got %0d want 2", offset);
        end
        rst_n = 0;
        #2;
        model_reset();
        tests_run++;
        if (hex !== 21'h1FFFFF || offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async got off=%0d hex=%b want off=0 hex=all ones", offset, hex);
        end
        rst_n = 1;
        tick();
        tests_run++;
        if (hex !== {S_D, S_E, S_1} || offset !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_restore got off=%0d hex=%b want off=0 hex=%b", offset, hex, {S_D, S_E, S_1});
        end
    endtask

    initial begin
        seg_tab[0] = S_D; seg_tab[1] = S_E; seg_tab[2] = S_1; seg_tab[3] = S_B;
        test_reset();
        test_auto();
        test_dir_right();
        test_manual();
        test_load();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
